// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Write-side companion to the read-only, word-addressed data memory. Stores
// from the datapath go into a small in-order FIFO. They are drained one at a
// time over a registered valid/acknowledge write port. Loads can optionally
// look up the pending stores, so they never see stale memory.
//
// Build option:
//   STORE_FWD_EN  When defined, ld_hit/ld_data forward the youngest pending
//                 store whose word address matches ld_addr[15:1]. When
//                 undefined, both outputs are tied to 0, no comparators are
//                 built, and software must wait for empty=1 before a
//                 dependent load.
//
// Parameters:
//   DEPTH   number of FIFO entries (power of two, >= 2)
//   PTR_W   pointer width, must equal log2(DEPTH)
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   st_valid   store request valid
//   st_ready   store can be accepted (buffer not full)
//   st_addr    store byte address; bit 0 ignored
//   st_data    store data
//   mem_we     registered write request to data memory
//   mem_addr   registered word address of the write
//   mem_wdata  registered write data
//   mem_ack    memory accepted the write this cycle (ignored while mem_we=0)
//   ld_addr    load byte address for the forwarding lookup
//   ld_hit     a pending store matches ld_addr[15:1] (combinational)
//   ld_data    forwarded data, 0 when ld_hit=0 (combinational)
//   empty      no pending stores and no write in flight
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] ld_addr,
    output logic        ld_hit,
    output logic [15:0] ld_data,
    output logic        empty
);

    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t           state_q, state_d;

    // FIFO storage: word address and data per entry
    logic [14:0]      ent_addr_q [DEPTH];
    logic [15:0]      ent_data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             mem_we_q, mem_we_d;
    logic [14:0]      mem_addr_q, mem_addr_d;
    logic [15:0]      mem_wdata_q, mem_wdata_d;

    logic             push;
    logic             pop;

    // Entry that becomes the write head after this edge
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] remain;
    logic [14:0]      head_addr;
    logic [15:0]      head_data;

    // Bits intentionally not consumed by the logic
    logic             unused_bits;
    assign unused_bits = ^{st_addr[0], ld_addr};

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // The full decision uses only the registered count. A pop in the same
    // cycle does not open a slot until the next cycle.
    assign st_ready = (count_q != FULL_CNT);
    assign push     = st_valid && st_ready;
    assign pop      = mem_we_q && mem_ack;

    assign empty     = (count_q == '0) && !mem_we_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // -------------------------------------------------------------------------
    // Pointer and occupancy update
    // -------------------------------------------------------------------------
    // NOTE: every variable driven in an always_comb gets a default on entry,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next write head
    // -------------------------------------------------------------------------
    // After a pop, the head moves to the next entry. If no stored entry is
    // left and a store is accepted in this same cycle, that store becomes the
    // head straight from the input. This gives one-cycle latency from an
    // empty buffer and avoids a bubble between back-to-back writes.
    always_comb begin
        head_ptr = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        remain   = pop ? count_q - CNT_W'(1) : count_q;

        if (remain != '0) begin
            head_addr = ent_addr_q[head_ptr];
            head_data = ent_data_q[head_ptr];
        end else begin
            head_addr = st_addr[15:1];
            head_data = st_data;
        end
    end

    // -------------------------------------------------------------------------
    // Drain FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                // count_d includes a store accepted this cycle
                if (count_d != '0) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                end
            end

            WRITE: begin
                // Hold the request stable until the memory acknowledges it
                if (pop) begin
                    if (count_d != '0) begin
                        mem_addr_d  = head_addr;
                        mem_wdata_d = head_data;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values and process ordering does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset. An entry is only
    // meaningful while the pointers and count mark it as pending, and those
    // are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= st_addr[15:1];
            ent_data_q[wr_ptr_q] <= st_data;
        end
    end

    // -------------------------------------------------------------------------
    // Load forwarding
    // -------------------------------------------------------------------------
`ifdef STORE_FWD_EN
    // Walk the entries from oldest (rd_ptr) to youngest. A later match
    // overrides an earlier one, so the youngest matching store wins. Only
    // registered entries are searched; a store being accepted this cycle is
    // not.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (ent_addr_q[rd_ptr_q + PTR_W'(i)] == ld_addr[15:1])) begin
                ld_hit  = 1'b1;
                ld_data = ent_data_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end
`else
    assign ld_hit  = 1'b0;
    assign ld_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer. The reference model is a queue of the
// stores that are accepted but not yet acknowledged. Expected behaviour is
// read from that queue:
//   - mem_we is high whenever something is pending.
//   - mem_addr/mem_wdata show the oldest pending store. With nothing pending
//     they hold the last value written (0 after reset).
//   - st_ready is low only when DEPTH stores are pending.
//   - The forwarding result is the newest pending store to the same word.
// Directed scenarios run first, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] ld_addr;
    logic        ld_hit;
    logic [15:0] ld_data;
    logic        empty;

    store_buffer #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];          // pending stores, oldest first
    logic [14:0] last_addr = '0;
    logic [15:0] last_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected forwarding result for a load address against the pending set
    function automatic void fwd_expect(input logic [15:0] la, output logic hit, output logic [15:0] dat);
        hit = 1'b0;
        dat = '0;
`ifdef STORE_FWD_EN
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].addr == la[15:1]) begin
                hit = 1'b1;
                dat = mq[i].data;
            end
        end
`endif
    endfunction

    // One clock cycle: drive at the falling edge, compare against the model,
    // then advance the model across the rising edge.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] d,
                         input logic ack, input logic [15:0] la);
        logic        exp_hit;
        logic [15:0] exp_ld;
        logic        accept;
        logic        ack_taken;
        ent_t        e;
        @(negedge clk);
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        mem_ack  = ack;
        ld_addr  = la;
        #1;
        check("st_ready", st_ready, mq.size() != DEPTH);
        check("empty",    empty,    mq.size() == 0);
        check("mem_we",   mem_we,   mq.size() != 0);
        if (mq.size() != 0) begin
            check("mem_addr",  mem_addr,  mq[0].addr);
            check("mem_wdata", mem_wdata, mq[0].data);
        end else begin
            check("mem_addr_hold",  mem_addr,  last_addr);
            check("mem_wdata_hold", mem_wdata, last_data);
        end
        fwd_expect(la, exp_hit, exp_ld);
        check("ld_hit",  ld_hit,  exp_hit);
        check("ld_data", ld_data, exp_ld);

        accept    = v && (mq.size() != DEPTH);
        ack_taken = ack && (mq.size() != 0);
        @(posedge clk);
        if (ack_taken) void'(mq.pop_front());
        if (accept) begin
            e.addr = a[15:1];
            e.data = d;
            mq.push_back(e);
        end
        if (mq.size() != 0) begin
            last_addr = mq[0].addr;
            last_data = mq[0].data;
        end
    endtask

    // Asynchronous reset, asserted 'dly' after the call, off the clock edges
    task automatic async_reset(input int dly);
        #(dly);
        rst      = 1'b1;
        st_valid = 1'b0;
        mem_ack  = 1'b0;
        #1;
        check("rst_mem_we",   mem_we,   1'b0);
        check("rst_empty",    empty,    1'b1);
        check("rst_st_ready", st_ready, 1'b1);
        mq.delete();
        last_addr = '0;
        last_data = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic exp_fwd_hit;
        int   ack_pct;

        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        mem_ack  = 1'b0;
        ld_addr  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("init_st_ready",  st_ready,  1'b1);
        check("init_empty",     empty,     1'b1);
        check("init_mem_we",    mem_we,    1'b0);
        check("init_mem_addr",  mem_addr,  15'h0000);
        check("init_mem_wdata", mem_wdata, 16'h0000);
        check("init_ld_hit",    ld_hit,    1'b0);
        check("init_ld_data",   ld_data,   16'h0000);

        // Single store with ack held: write on the next cycle, empty after
        cycle(1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0000);
        #1;
        check("t1_we",    mem_we,    1'b1);
        check("t1_addr",  mem_addr,  15'h0008);
        check("t1_wdata", mem_wdata, 16'hBEEF);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        #1;
        check("t1_empty", empty,  1'b1);
        check("t1_we_lo", mem_we, 1'b0);

        // Fill to full with no ack
        cycle(1'b1, 16'h0002, 16'h1111, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0004, 16'h2222, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0006, 16'h3333, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0008, 16'h4444, 1'b0, 16'h0000);
        #1;
        check("t2_full",  st_ready, 1'b0);
        check("t2_addr",  mem_addr, 15'h0001);
        cycle(1'b1, 16'h000A, 16'h5555, 1'b0, 16'h0000);
        #1;
        check("t2_reject", st_ready, 1'b0);
        check("t2_hold",   mem_addr, 15'h0001);

        // One ack while full and st_valid=1: pop only, then the fifth store gets in
        cycle(1'b1, 16'h000A, 16'h5555, 1'b1, 16'h0000);
        #1;
        check("t3_ready", st_ready, 1'b1);
        check("t3_addr",  mem_addr, 15'h0002);
        cycle(1'b1, 16'h000A, 16'h5555, 1'b0, 16'h0000);
        #1;
        check("t3_full",  st_ready, 1'b0);
        repeat (5) cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        #1;
        check("t3_drained", empty, 1'b1);

        // Three queued stores drain back to back
        cycle(1'b1, 16'h0002, 16'hA001, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0004, 16'hA002, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0006, 16'hA003, 1'b0, 16'h0000);
        #1;
        check("t4_we0",   mem_we,   1'b1);
        check("t4_addr0", mem_addr, 15'h0001);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        #1;
        check("t4_we1",   mem_we,   1'b1);
        check("t4_addr1", mem_addr, 15'h0002);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        #1;
        check("t4_we2",   mem_we,   1'b1);
        check("t4_addr2", mem_addr, 15'h0003);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        #1;
        check("t4_done",  mem_we,   1'b0);

        // Two stores to the same word: forwarding returns the younger one
`ifdef STORE_FWD_EN
        exp_fwd_hit = 1'b1;
`else
        exp_fwd_hit = 1'b0;
`endif
        cycle(1'b1, 16'h0020, 16'hAAAA, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0021, 16'hBBBB, 1'b0, 16'h0000);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0020);
        #1;
        check("t5_hit",  ld_hit,  exp_fwd_hit);
        check("t5_data", ld_data, exp_fwd_hit ? 16'hBBBB : 16'h0000);
        cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0030);
        #1;
        check("t5_miss",      ld_hit,  1'b0);
        check("t5_miss_data", ld_data, 16'h0000);
        repeat (3) cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);

        // Reset while a write is in flight with three pending
        cycle(1'b1, 16'h0040, 16'hC001, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0042, 16'hC002, 1'b0, 16'h0000);
        cycle(1'b1, 16'h0044, 16'hC003, 1'b0, 16'h0000);
        #1;
        check("t6_we_pre", mem_we, 1'b1);
        async_reset(2);
        repeat (3) cycle(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000);
        #1;
        check("t6_no_write", mem_we, 1'b0);
        check("t6_empty",    empty,  1'b1);

        // Randomized traffic over a small address range so forwarding hits
        for (int i = 0; i < 3000; i++) begin
            ack_pct = (i / 500) * 20;
            if (ack_pct > 100) ack_pct = 100;
            if ($urandom_range(999, 0) < 3) begin
                async_reset(int'($urandom_range(3, 1)));
            end
            cycle(logic'($urandom_range(99, 0) < 60),
                  16'($urandom_range(15, 0)),
                  16'($urandom),
                  logic'($urandom_range(99, 0) < ack_pct),
                  16'($urandom_range(17, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
